// File: rtl/board_pix_pkg.sv
// Cell codes shared by the board renderer, the colour-mapping stage and the game controller.
package board_pix_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MOVING = 2'b01,
        FIXED  = 2'b10,
        BORDER = 2'b11
    } cell_code_t;

    localparam int CNT_W = 12;

endpackage

// File: rtl/board_pix_cnt.sv
// Raster position tracker: pixel column x and line y recovered from the incoming vs/de timing.
module board_pix_cnt
    import board_pix_pkg::*;
#(
    parameter int unsigned H_ACT = 12'd1280,
    parameter int unsigned V_ACT = 12'd720
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic             vs_in,
    input  logic             de_in,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             vs_rise
);

    localparam logic [CNT_W-1:0] X_MAX = CNT_W'(H_ACT - 1);
    localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(V_ACT - 1);

    logic vs_d;
    logic de_d;
    logic de_fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

    assign vs_rise = vs_in & ~vs_d;
    assign de_fall = de_d & ~de_in;

    // A new frame clears y even if a line ends on the same cycle.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
            x    <= '0;
            y    <= '0;
        end else begin
            vs_d <= vs_in;
            de_d <= de_in;
            if (de_in)
                x <= sat_inc(x, X_MAX);
            else if (de_fall)
                x <= '0;
            if (vs_rise)
                y <= '0;
            else if (de_fall)
                y <= sat_inc(y, Y_MAX);
        end
    end

endmodule

// File: rtl/board_pix_gen.sv
// Playfield pixel generator: maps raster position to a 2-bit cell code with 2-cycle latency.
// Optional grid lines inside the playfield are built when GRID_LINES_EN is defined.
module board_pix_gen
    import board_pix_pkg::*;
#(
    parameter int unsigned H_ACT    = 12'd1280,
    parameter int unsigned V_ACT    = 12'd720,
    parameter int unsigned CELL_PX  = 32,
    parameter int unsigned COLS     = 10,
    parameter int unsigned ROWS     = 20,
    parameter int unsigned BOARD_X0 = 448,
    parameter int unsigned BOARD_Y0 = 8
) (
    input  logic              pix_clk,
    input  logic              rst,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    output logic [4:0]        row_addr,
    input  logic [COLS-1:0]   row_data,
    input  logic [15:0]       piece_mask,
    input  logic signed [4:0] piece_col,
    input  logic signed [4:0] piece_row,
    output logic [1:0]        pix_data,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out
);

    localparam int          CELL_SH  = $clog2(CELL_PX);
    localparam logic [12:0] X_LO     = 13'(BOARD_X0);
    localparam logic [12:0] X_HI     = 13'(BOARD_X0 + (COLS + 2) * CELL_PX);
    localparam logic [12:0] Y_LO     = 13'(BOARD_Y0);
    localparam logic [12:0] Y_HI     = 13'(BOARD_Y0 + (ROWS + 2) * CELL_PX);
    localparam logic [7:0]  LAST_COL = 8'(COLS + 1);
    localparam logic [7:0]  LAST_ROW = 8'(ROWS + 1);

    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic              vs_rise;

    logic [15:0]       sh_mask;
    logic signed [4:0] sh_col;
    logic signed [4:0] sh_row;

    logic [12:0]       x_off;
    logic [12:0]       y_off;
    logic [7:0]        cx;
    logic [7:0]        cy;
    logic              in_region;
    logic              in_rows;
    logic              in_play;
    logic signed [13:0] dx;
    logic signed [13:0] dy;
    logic              piece_hit;
    logic [4:0]        row_addr_nxt;

    logic              vs_p1, hs_p1, vld_p1, region_p1, hit_p1;
    logic [7:0]        cx_p1, cy_p1;
    logic              vs_p2, hs_p2, vld_p2, region_p2, hit_p2, edge_p2;
    logic [7:0]        cx_p2;
    logic              fixed_bit;

    board_pix_cnt #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) u_cnt (
        .pix_clk (pix_clk),
        .rst     (rst),
        .vs_in   (vs_in),
        .de_in   (de_in),
        .x       (x),
        .y       (y),
        .vs_rise (vs_rise)
    );

    // Piece state is latched once per frame so the drawn piece never tears.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            sh_mask <= '0;
            sh_col  <= '0;
            sh_row  <= '0;
        end else if (vs_rise) begin
            sh_mask <= piece_mask;
            sh_col  <= piece_col;
            sh_row  <= piece_row;
        end
    end

    always_comb begin
        x_off        = {1'b0, x} - X_LO;
        y_off        = {1'b0, y} - Y_LO;
        cx           = 8'(x_off >> CELL_SH);
        cy           = 8'(y_off >> CELL_SH);
        in_region    = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                       ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
        in_rows      = in_region && (cy >= 8'd1) && (cy <= 8'(ROWS));
        in_play      = in_rows && (cx >= 8'd1) && (cx <= 8'(COLS));
        dx           = $signed({6'b0, cx}) - 14'sd1 - 14'(sh_col);
        dy           = $signed({6'b0, cy}) - 14'sd1 - 14'(sh_row);
        piece_hit    = in_play && (dx >= 14'sd0) && (dx < 14'sd4) &&
                       (dy >= 14'sd0) && (dy < 14'sd4) && sh_mask[{dy[1:0], dx[1:0]}];
        row_addr_nxt = in_rows ? 5'(cy - 8'd1) : 5'd0;
    end

    // Stage 1: cell coordinates, region flag, piece hit, board RAM address
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            vs_p1     <= 1'b0;
            hs_p1     <= 1'b0;
            vld_p1    <= 1'b0;
            region_p1 <= 1'b0;
            hit_p1    <= 1'b0;
            cx_p1     <= '0;
            cy_p1     <= '0;
            row_addr  <= '0;
        end else begin
            vs_p1     <= vs_in;
            hs_p1     <= hs_in;
            vld_p1    <= de_in;
            region_p1 <= in_region;
            hit_p1    <= piece_hit;
            cx_p1     <= cx;
            cy_p1     <= cy;
            row_addr  <= row_addr_nxt;
        end
    end

    // Stage 2: border classification; row_data arrives alongside this stage
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            vs_p2     <= 1'b0;
            hs_p2     <= 1'b0;
            vld_p2    <= 1'b0;
            region_p2 <= 1'b0;
            hit_p2    <= 1'b0;
            edge_p2   <= 1'b0;
            cx_p2     <= '0;
        end else begin
            vs_p2     <= vs_p1;
            hs_p2     <= hs_p1;
            vld_p2    <= vld_p1;
            region_p2 <= region_p1;
            hit_p2    <= hit_p1;
            edge_p2   <= (cx_p1 == 8'd0) || (cx_p1 == LAST_COL) ||
                         (cy_p1 == 8'd0) || (cy_p1 == LAST_ROW);
            cx_p2     <= cx_p1;
        end
    end

`ifdef GRID_LINES_EN
    logic grid_hit;
    logic grid_p1;
    logic grid_p2;

    assign grid_hit = in_play && ((x_off[CELL_SH-1:0] == '0) || (y_off[CELL_SH-1:0] == '0));

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            grid_p1 <= 1'b0;
            grid_p2 <= 1'b0;
        end else begin
            grid_p1 <= grid_hit;
            grid_p2 <= grid_p1;
        end
    end
`endif

    always_comb begin
        fixed_bit = 1'b0;
        for (int c = 0; c < int'(COLS); c++)
            if (cx_p2 == 8'(c + 1))
                fixed_bit = row_data[c];
        if (!vld_p2 || !region_p2)
            pix_data = EMPTY;
        else if (edge_p2)
            pix_data = BORDER;
        else if (hit_p2)
            pix_data = MOVING;
`ifdef GRID_LINES_EN
        else if (grid_p2)
            pix_data = BORDER;
`endif
        else if (fixed_bit)
            pix_data = FIXED;
        else
            pix_data = EMPTY;
    end

    assign vs_out = vs_p2;
    assign hs_out = hs_p2;
    assign de_out = vld_p2;

endmodule
